// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
//  Module      : decode_queue
//  Description : Instruction buffer FIFO with combinational decode of head.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [6:0]       opcode,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7,
    output logic [5:0]       rs1_addr,
    output logic [5:0]       rs2_addr,
    output logic [5:0]       rd_addr,
    output logic [31:0]      imm,
    output logic             illegal,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_flw    = 7'b0000111;
    localparam logic [6:0] c_op_fsw    = 7'b0100111;
    localparam logic [6:0] c_op_falu   = 7'b1010011;
    localparam logic [6:0] c_op_csr    = 7'b1110011;

    logic [31:0]      r_instr_mem [DEPTH];
    logic [31:0]      r_pc_mem    [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic        w_push;
    logic        w_pop;
    logic        w_out_valid;
    logic [31:0] w_instr;
    logic [6:0]  w_op;
    logic [6:0]  w_f7;
    logic [31:0] w_imm;
    logic        w_illegal;
    logic        w_rs1_fp;
    logic        w_rs2_fp;
    logic        w_rd_fp;
    logic [5:0]  w_rs1;
    logic [5:0]  w_rs2;
    logic [5:0]  w_rd;

    assign in_ready    = (r_count < c_depth);
    assign w_out_valid = (r_count != '0);
    assign w_push      = in_valid && in_ready && !flush;
    assign w_pop       = w_out_valid && out_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
        end
    end

    // Storage carries no reset; validity is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= in_instr;
            r_pc_mem[r_wr_ptr]    <= in_pc;
        end
    end

    assign w_instr = r_instr_mem[r_rd_ptr];
    assign w_op    = w_instr[6:0];
    assign w_f7    = w_instr[31:25];

    always_comb begin
        w_imm     = '0;
        w_illegal = 1'b0;
        case (w_op)
            c_op_itype, c_op_load, c_op_flw, c_op_jalr:
                w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
            c_op_store, c_op_fsw:
                w_imm = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            c_op_branch:
                w_imm = {{20{w_instr[31]}}, w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
            c_op_auipc, c_op_lui:
                w_imm = {w_instr[31:12], 12'b0};
            c_op_jal:
                w_imm = {{12{w_instr[31]}}, w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
            c_op_rtype, c_op_falu, c_op_csr:
                w_imm = '0;
            default:
                w_illegal = 1'b1;
        endcase
    end

    // Integer-side FP ops (moves, converts, compares) keep one operand in the int file.
    assign w_rs1_fp = (w_op == c_op_falu) && (w_f7 != 7'b1111000) && (w_f7 != 7'b1101000);
    assign w_rs2_fp = (w_op == c_op_fsw) || (w_op == c_op_falu);
    assign w_rd_fp  = (w_op == c_op_flw) ||
                      ((w_op == c_op_falu) && (w_f7 != 7'b1110000) &&
                       (w_f7 != 7'b1100000) && (w_f7 != 7'b1010000));

    assign w_rd  = ((w_op == c_op_store) || (w_op == c_op_fsw) || (w_op == c_op_branch))
                   ? 6'd0 : {w_rd_fp, w_instr[11:7]};
    assign w_rs1 = ((w_op == c_op_lui) || (w_op == c_op_auipc) || (w_op == c_op_jal))
                   ? 6'd0 : {w_rs1_fp, w_instr[19:15]};
    assign w_rs2 = ((w_op == c_op_rtype) || (w_op == c_op_store) || (w_op == c_op_fsw) ||
                    (w_op == c_op_branch) || (w_op == c_op_falu))
                   ? {w_rs2_fp, w_instr[24:20]} : 6'd0;

    assign out_valid = w_out_valid;
    assign count     = r_count;
    assign out_pc    = w_out_valid ? r_pc_mem[r_rd_ptr] : 32'd0;
    assign opcode    = w_out_valid ? w_op : 7'd0;
    assign funct3    = w_out_valid ? w_instr[14:12] : 3'd0;
    assign funct7    = w_out_valid ? w_f7 : 7'd0;
    assign rs1_addr  = w_out_valid ? w_rs1 : 6'd0;
    assign rs2_addr  = w_out_valid ? w_rs2 : 6'd0;
    assign rd_addr   = w_out_valid ? w_rd : 6'd0;
    assign imm       = w_out_valid ? w_imm : 32'd0;
    assign illegal   = w_out_valid && w_illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_queue
//  Description : Directed self-checking bench for decode_queue (DEPTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_instr = '0;
    logic [31:0]      in_pc = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_pc;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [5:0]       rs1_addr;
    logic [5:0]       rs2_addr;
    logic [5:0]       rd_addr;
    logic [31:0]      imm;
    logic             illegal;
    logic [CNT_W-1:0] count;

    int vectors = 0;
    int miscompares = 0;

    decode_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .imm(imm), .illegal(illegal), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        rst = 1'b0;
        step();

        // addi x1,x0,5 at pc 0x100
        push(32'h00500093, 32'h100);
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_opcode", 32'(opcode), 32'h13);
        chk("addi_rd", 32'(rd_addr), 32'h01);
        chk("addi_rs1", 32'(rs1_addr), 32'h00);
        chk("addi_rs2", 32'(rs2_addr), 32'h00);
        chk("addi_imm", imm, 32'd5);
        chk("addi_pc", out_pc, 32'h100);
        chk("addi_count", 32'(count), 32'd1);
        pop();
        chk("empty_valid", 32'(out_valid), 32'd0);
        chk("empty_opcode", 32'(opcode), 32'd0);
        chk("empty_pc", out_pc, 32'd0);

        // Fill to DEPTH with pointers starting at 1 so the run wraps
        for (int k = 0; k < DEPTH; k++)
            push((32'(k + 1) << 20) | 32'h13, 32'h200 + 32'(4 * k));
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_head_pc", out_pc, 32'h200);

        // Full: dequeue with in_valid held; enqueue must be blocked this edge
        in_valid  = 1'b1;
        in_instr  = 32'h00500013;
        in_pc     = 32'h210;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("blocked_count", 32'(count), 32'd3);
        chk("blocked_head_pc", out_pc, 32'h204);
        step();
        in_valid = 1'b0;
        chk("refill_count", 32'(count), 32'd4);
        for (int k = 1; k <= DEPTH; k++) begin
            chk("order_pc", out_pc, 32'h200 + 32'(4 * k));
            chk("order_imm", imm, 32'(k + 1));
            pop();
        end
        chk("drained_count", 32'(count), 32'd0);

        // FP tagging
        push(32'h00A5F0D3, 32'h300);
        chk("fadd_rs1", 32'(rs1_addr), 32'h2B);
        chk("fadd_rs2", 32'(rs2_addr), 32'h2A);
        chk("fadd_rd", 32'(rd_addr), 32'h21);
        pop();
        push(32'hE00080D3, 32'h304);
        chk("fmvxw_rd", 32'(rd_addr), 32'h01);
        chk("fmvxw_rs1", 32'(rs1_addr), 32'h21);
        chk("fmvxw_funct7", 32'(funct7), 32'h70);
        pop();
        push(32'h00112223, 32'h308);
        chk("sw_rd", 32'(rd_addr), 32'h00);
        chk("sw_imm", imm, 32'd4);
        chk("sw_rs1", 32'(rs1_addr), 32'h02);
        chk("sw_rs2", 32'(rs2_addr), 32'h01);
        chk("sw_funct3", 32'(funct3), 32'd2);
        pop();

        // Branch immediate and illegal opcode
        push(32'hFE000EE3, 32'h30C);
        chk("br_imm", imm, 32'hFFFFFFFC);
        chk("br_rd", 32'(rd_addr), 32'h00);
        chk("br_illegal", 32'(illegal), 32'd0);
        pop();
        push(32'h0000007F, 32'h310);
        chk("ill_illegal", 32'(illegal), 32'd1);
        chk("ill_imm", imm, 32'd0);
        pop();

        // Flush with a concurrent enqueue
        for (int k = 0; k < 3; k++)
            push(32'h00000013, 32'h400 + 32'(4 * k));
        chk("preflush_count", 32'(count), 32'd3);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00100093;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset mid-stream, checked before the next edge
        push(32'h00500093, 32'h500);
        push(32'h00600113, 32'h504);
        chk("prerst_count", 32'(count), 32'd2);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_rd", 32'(rd_addr), 32'd0);
        chk("arst_imm", imm, 32'd0);
        chk("arst_pc", out_pc, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("post_rst_count", 32'(count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction-buffer entries, power of two, at least 2.
REQ-002 SHALL have parameter CNT_W, default $clog2(DEPTH)+1, occupancy counter width.
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports in_valid/in_ready, input/output, 1 each, fetch-side handshake.
REQ-006 SHALL have ports in_instr and in_pc, input, 32 each, fetched word and its PC.
REQ-007 SHALL have port flush, input, 1, synchronous discard of all buffered entries.
REQ-008 SHALL have ports out_valid/out_ready, output/input, 1 each, issue-side handshake.
REQ-009 SHALL have port out_pc, output, 32, PC of head entry.
REQ-010 SHALL have ports opcode, funct3 and funct7, output, 7/3/7, instr[6:0], instr[14:12] and instr[31:25] of head.
REQ-011 SHALL have ports rs1_addr, rs2_addr and rd_addr, output, 6 each, {fp_tag, 5-bit index}.
REQ-012 SHALL have port imm, output, 32, sign-extended immediate.
REQ-013 SHALL have port illegal, output, 1, head opcode unsupported.
REQ-014 SHALL have port count, output, CNT_W, current occupancy.

Function
REQ-015 SHALL enqueue at a rising edge when in_valid&&in_ready, writing {in_instr,in_pc} at wr_ptr.
REQ-016 SHALL drive in_ready = (count<DEPTH), registered-state only, with no combinational path from out_ready.
REQ-017 SHALL dequeue at a rising edge when out_valid&&out_ready, advancing rd_ptr.
REQ-018 SHALL drive out_valid = (count!=0); an entry enqueued at edge N appears at the output after edge N (1-cycle latency), with no empty bypass.
REQ-019 SHALL update count on simultaneous enqueue and dequeue as unchanged; when full, in_ready=0 blocks enqueue even if dequeue occurs.
REQ-020 SHALL wrap pointers modulo DEPTH.
REQ-021 SHALL decode the head entry combinationally from buffer storage.
REQ-022 SHALL recognise opcodes Rtype 0110011, Itype 0010011, Load 0000011, Store 0100011, Branch 1100011, JALR 1100111, JAL 1101111, AUIPC 0010111, LUI 0110111, FLW 0000111, FSW 0100111, FALU 1010011 and CSR 1110011; any other opcode gives illegal=1 and imm=0.
REQ-023 SHALL form imm as follows: I-format (Itype/Load/FLW/JALR) sext(instr[31:20]); S-format (Store/FSW) sext({[31:25],[11:7]}); B-format sext({[31],[7],[30:25],[11:8],0}); U-format (AUIPC/LUI) {[31:12],12'b0}; J-format sext({[31],[19:12],[20],[30:21],0}); CSR 0.
REQ-024 SHALL set fp_tag for rs1 for FALU, except when funct7 is 1111000 (FMV.W.X) or 1101000 (FCVT.S.W).
REQ-025 SHALL set fp_tag for rs2 for FSW and FALU.
REQ-026 SHALL set fp_tag for rd for FLW and FALU, except when funct7 is 1110000 (FMV.X.W/FCLASS), 1100000 (FCVT.W.S) or 1010000 (FEQ/FLT/FLE).
REQ-027 SHALL force rd_addr=0 for Store, FSW and Branch.
REQ-028 SHALL force rs1_addr=0 for LUI, AUIPC and JAL.
REQ-029 SHALL force rs2_addr=0 for all except Rtype, Store, FSW, Branch and FALU.
REQ-030 SHALL drive all decoded outputs and out_pc to 0 when out_valid=0.
REQ-031 SHALL, on flush at an edge, zero count, wr_ptr and rd_ptr, and ignore a same-cycle enqueue or dequeue.

Reset
REQ-032 SHALL, on rst assertion at any time including mid-transfer, immediately clear count, wr_ptr and rd_ptr, giving out_valid=0, in_ready=1 and all decoded outputs 0.
REQ-033 SHALL leave buffer storage unreset.

Verification
REQ-034 SHALL verify: reset, enqueue 0x00500093 (addi x1,x0,5) with pc 0x100 -> next cycle out_valid=1, opcode=0010011, rd_addr=0x01, rs1_addr=0x00, rs2_addr=0, imm=5, out_pc=0x100.
REQ-035 SHALL verify: with out_ready=0, enqueue DEPTH words -> in_ready=0 and count=DEPTH; pulse out_ready plus in_valid -> count stays DEPTH-1 then refills, FIFO order preserved across pointer wrap.
REQ-036 SHALL verify FP tagging: 0x00A5F0D3 (fadd.s f1,f11,f10) -> rs1=0x2B, rs2=0x2A, rd=0x21; 0xE00080D3 (fmv.x.w x1,f1) -> rd=0x01, rs1=0x21; 0x00112223 (sw x1,4(x2)) -> rd=0, imm=4.
REQ-037 SHALL verify: Branch 0xFE000EE3 -> imm=0xFFFFFFFC; opcode 1111111 -> illegal=1, imm=0.
REQ-038 SHALL verify: three entries buffered, assert flush together with in_valid -> next cycle count=0, out_valid=0; assert rst asynchronously mid-stream -> outputs clear before the next clock edge.
